// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage LEGv8 pipe: stage enables, flush/bubble,
// operand forwarding, data-memory freeze and saturating stall/flush statistics.
module pipe_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_rd_flags,
  input  logic [4:0]       ex_rn,
  input  logic [4:0]       ex_rm,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memtoreg,
  input  logic             ex_flagwrite,
  input  logic             ex_br_taken,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             memwb_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_err
);

  typedef enum logic {RUN = 1'b0, MWAIT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [15:0]      TO_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        pend_flush;
  logic [15:0] wait_cnt;
  logic        freeze, timeout, br_any, lu_haz, flag_haz;

  // MWAIT stalls regardless of mem_req; in RUN only an unanswered request freezes
  assign freeze   = !mem_ready && (state == MWAIT || mem_req);
  // wait_cnt holds MWAIT cycles already completed, so the pipe sits in MWAIT exactly MEM_TIMEOUT cycles
  assign timeout  = (state == MWAIT) && !mem_ready && (wait_cnt == TO_LAST);
  assign br_any   = ex_br_taken || pend_flush;
  assign lu_haz   = ex_memtoreg && ex_regwrite && (ex_rd != 5'd31) &&
                    ((id_use_rn && id_rn == ex_rd) || (id_use_rm && id_rm == ex_rd));
  assign flag_haz = id_rd_flags && ex_flagwrite;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (mem_req && !mem_ready) state_nxt = MWAIT;
      MWAIT:   if (mem_ready || timeout)  state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    idex_we      = 1'b1;
    exmem_we     = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    memwb_bubble = 1'b0;
    if (reset) begin
      pc_we = 1'b1;
    end else if (freeze) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      idex_we      = 1'b0;
      exmem_we     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (br_any) begin
      // younger instructions are discarded, so any ID-stage stall is moot
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (lu_haz || flag_haz) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [4:0] r);
    if (mem_regwrite && mem_rd != 5'd31 && mem_rd == r)     return 2'b01;
    else if (wb_regwrite && wb_rd != 5'd31 && wb_rd == r)   return 2'b10;
    else                                                    return 2'b00;
  endfunction

  assign fwd_a = fwd_sel(ex_rn);
  assign fwd_b = fwd_sel(ex_rm);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_flush <= 1'b0;
      wait_cnt   <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      mem_err    <= 1'b0;
    end else begin
      if (freeze) pend_flush <= pend_flush || ex_br_taken;
      else        pend_flush <= 1'b0;
      if (state == RUN)        wait_cnt <= '0;
      else if (state == MWAIT) wait_cnt <= wait_cnt + 16'd1;
      if (!pc_we && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
      if (!freeze && br_any && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + 1'b1;
      if (timeout) mem_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, forwarding, flag stall, branch flush,
// memory freeze/release, timeout, counter saturation and async reset.
module tb_pipe_hazard_ctrl;
  localparam int CNT_W = 4;

  logic clk = 1'b0, reset = 1'b1;
  logic [4:0] id_rn, id_rm, ex_rn, ex_rm, ex_rd, mem_rd, wb_rd;
  logic id_use_rn, id_use_rm, id_rd_flags, ex_regwrite, ex_memtoreg, ex_flagwrite, ex_br_taken;
  logic mem_regwrite, mem_req, mem_ready, wb_regwrite;
  logic pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_bubble, memwb_bubble, mem_err;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  int checks = 0, failures = 0;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_use_rn(id_use_rn),
    .id_use_rm(id_use_rm), .id_rd_flags(id_rd_flags), .ex_rn(ex_rn), .ex_rm(ex_rm),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .ex_flagwrite(ex_flagwrite), .ex_br_taken(ex_br_taken), .mem_rd(mem_rd),
    .mem_regwrite(mem_regwrite), .mem_req(mem_req), .mem_ready(mem_ready), .wb_rd(wb_rd),
    .wb_regwrite(wb_regwrite), .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
    .exmem_we(exmem_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .memwb_bubble(memwb_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .mem_err(mem_err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rn = 0; id_rm = 0; id_use_rn = 0; id_use_rm = 0; id_rd_flags = 0;
    ex_rn = 0; ex_rm = 0; ex_rd = 0; ex_regwrite = 0; ex_memtoreg = 0; ex_flagwrite = 0;
    ex_br_taken = 0; mem_rd = 0; mem_regwrite = 0; mem_req = 0; mem_ready = 0;
    wb_rd = 0; wb_regwrite = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); reset = 1'b1; tick(); reset = 1'b0; #1;
  endtask

  // packed {pc,ifid,idex,exmem} enables
  function automatic logic [3:0] wes();
    return {pc_we, ifid_we, idex_we, exmem_we};
  endfunction

  initial begin
    do_reset();
    chk("rst_we", wes(), 4'hF);
    chk("rst_flush", {ifid_flush, idex_bubble, memwb_bubble}, 3'b000);
    chk("rst_fwd", {fwd_a, fwd_b}, 4'b0000);
    chk("rst_cnt", {stall_cnt, flush_cnt, mem_err}, 9'd0);

    // 1: LDUR X1 in EX, ADDS X2,X1,X3 in ID
    ex_memtoreg = 1; ex_regwrite = 1; ex_rd = 1;
    id_use_rn = 1; id_rn = 1; id_use_rm = 1; id_rm = 3; #1;
    chk("lu_we", wes(), 4'b0011);
    chk("lu_bubble", idex_bubble, 1'b1);
    tick();
    chk("lu_stall_cnt", stall_cnt, 4'd1);
    ex_memtoreg = 0; ex_regwrite = 0; ex_rd = 0; mem_rd = 1; mem_regwrite = 1; #1;
    chk("lu_once", {wes(), idex_bubble}, 5'b11110);
    tick();
    mem_rd = 0; mem_regwrite = 0; wb_rd = 1; wb_regwrite = 1;
    id_use_rn = 0; id_use_rm = 0; ex_rn = 1; ex_rm = 3; #1;
    chk("lu_fwd", {fwd_a, fwd_b}, 4'b1000);
    tick();
    chk("lu_stall_hold", stall_cnt, 4'd1);

    // load to XZR never stalls
    idle(); ex_memtoreg = 1; ex_regwrite = 1; ex_rd = 31; id_use_rn = 1; id_rn = 31; #1;
    chk("lu_x31", wes(), 4'hF);

    // 2: back-to-back ALU forwarding, MEM beats WB, X31 never forwarded
    idle(); mem_rd = 1; mem_regwrite = 1; wb_rd = 1; wb_regwrite = 1; ex_rn = 1; ex_rm = 1; #1;
    chk("fwd_mem", {fwd_a, fwd_b}, 4'b0101);
    chk("fwd_nostall", wes(), 4'hF);
    mem_rd = 31; wb_rd = 31; ex_rn = 31; ex_rm = 31; #1;
    chk("fwd_x31", {fwd_a, fwd_b}, 4'b0000);
    mem_rd = 5; mem_regwrite = 0; wb_rd = 7; ex_rn = 5; ex_rm = 7; #1;
    chk("fwd_nowr", {fwd_a, fwd_b}, 4'b0010);

    // 3: flag stall then taken branch overriding a concurrent load-use
    do_reset();
    ex_flagwrite = 1; id_rd_flags = 1; #1;
    chk("flag_we", {wes(), idex_bubble}, 5'b00111);
    tick();
    idle(); ex_br_taken = 1;
    ex_memtoreg = 1; ex_regwrite = 1; ex_rd = 2; id_use_rn = 1; id_rn = 2; #1;
    chk("br_flush", {wes(), ifid_flush, idex_bubble}, 6'b111111);
    tick();
    chk("br_cnt", {stall_cnt, flush_cnt}, {4'd1, 4'd1});

    // 4: three-cycle memory wait with a taken branch mid-wait
    do_reset();
    mem_req = 1; #1;
    chk("frz1", {wes(), memwb_bubble}, 5'b00001);
    tick();
    ex_br_taken = 1; #1;
    chk("frz2", {wes(), ifid_flush, memwb_bubble}, 6'b000001);
    tick();
    ex_br_taken = 0; #1;
    chk("frz3", wes(), 4'h0);
    tick();
    mem_ready = 1; #1;
    chk("rel_stall_cnt", stall_cnt, 4'd3);
    chk("rel_flush", {wes(), ifid_flush, idex_bubble, memwb_bubble}, 7'b1111110);
    tick();
    idle(); #1;
    chk("pend_clr", {wes(), ifid_flush}, 5'b11110);
    chk("rel_flush_cnt", flush_cnt, 4'd1);

    // 5: timeout after 4 MWAIT cycles, mem_err sticky
    do_reset();
    mem_req = 1; tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_wait%0d", i), {wes(), mem_err}, 5'b00000);
      tick();
    end
    mem_req = 0; #1;
    chk("to_run", {wes(), mem_err}, 5'b11111);
    chk("to_stall_cnt", stall_cnt, 4'd5);
    tick(); tick();
    chk("to_sticky", mem_err, 1'b1);

    // saturation of stall_cnt
    do_reset();
    id_rd_flags = 1; ex_flagwrite = 1;
    for (int i = 0; i < 20; i++) tick();
    chk("stall_sat", stall_cnt, 4'hF);

    // 6: async reset mid-MWAIT with pending flush and load-use on the inputs
    do_reset();
    mem_req = 1; tick(); ex_br_taken = 1; tick(); ex_br_taken = 0;
    ex_memtoreg = 1; ex_regwrite = 1; ex_rd = 4; id_use_rm = 1; id_rm = 4;
    #2 reset = 1'b1; #1;
    chk("arst_we", {wes(), ifid_flush, idex_bubble, memwb_bubble}, 7'b1111000);
    chk("arst_cnt", {stall_cnt, flush_cnt, mem_err}, 9'd0);
    tick();
    idle(); reset = 1'b0; #1;
    chk("arst_run", {wes(), ifid_flush}, 5'b11110);
    tick();
    chk("arst_noflush", flush_cnt, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
